// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 scan-out of a 160x120 frame buffer: generates timing, reads the
// stored image through the RAM read port and upscales it to a grayscale RGB stream.
module vga_frame_reader #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LAT      = 1,
    parameter int LUMA_HI     = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] rddata,
    output logic [14:0] rdaddr,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
    } flags_t;

    logic [9:0] hcnt_reg;
    logic [9:0] hcnt_next;
    logic [9:0] vcnt_reg;
    logic [9:0] vcnt_next;

    always_comb begin
        hcnt_next = hcnt_reg + 10'd1;
        vcnt_next = vcnt_reg;
        if (hcnt_reg == H_LAST) begin
            hcnt_next = '0;
            vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else begin
            hcnt_reg <= hcnt_next;
            vcnt_reg <= vcnt_next;
        end
    end

    flags_t flags_stage0;

    always_comb begin
        flags_stage0        = '0;
        flags_stage0.active = (hcnt_reg < H_VIS) && (vcnt_reg < V_VIS);
        flags_stage0.hs     = (hcnt_reg >= HS_FIRST) && (hcnt_reg <= HS_LAST);
        flags_stage0.vs     = (vcnt_reg >= VS_FIRST) && (vcnt_reg <= VS_LAST);
        flags_stage0.first  = (hcnt_reg == '0) && (vcnt_reg == '0);
    end

    // Image coordinates are the screen counters with the upscale bits dropped.
    logic [14:0] rdaddr_reg;
    logic [14:0] rdaddr_next;

    always_comb begin
        rdaddr_next = '0;
        if (flags_stage0.active) begin
            rdaddr_next = {hcnt_reg[SCALE_SHIFT +: 8], vcnt_reg[SCALE_SHIFT +: 7]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdaddr_reg <= '0;
        end else begin
            rdaddr_reg <= rdaddr_next;
        end
    end

    assign rdaddr = rdaddr_reg;

    // One stage covers the address register, RD_LAT more cover the RAM, so the
    // last stage lines up with the cycle in which rddata holds this pixel.
    flags_t flag_pipe_reg [RD_LAT+1];

    generate
        for (genvar gi = 0; gi <= RD_LAT; gi++) begin : gen_delay
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    flag_pipe_reg[gi] <= '0;
                end else begin
                    if (gi == 0) begin
                        flag_pipe_reg[gi] <= flags_stage0;
                    end else begin
                        flag_pipe_reg[gi] <= flag_pipe_reg[(gi == 0) ? 0 : gi - 1];
                    end
                end
            end
        end
    endgenerate

    flags_t     flags_out;
    logic [7:0] luma;

    assign flags_out = flag_pipe_reg[RD_LAT];
    assign luma      = (LUMA_HI != 0) ? rddata[15:8] : rddata[7:0];

    logic       hsync_n_reg;
    logic       vsync_n_reg;
    logic       blank_n_reg;
    logic [7:0] pixel_reg;
    logic [7:0] pixel_next;
    logic       frame_start_reg;

    // rddata is only looked at for visible pixels, so X during blanking never reaches r/g/b.
    always_comb begin
        pixel_next = 8'd0;
        if (flags_out.active) begin
            pixel_next = luma;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_n_reg     <= 1'b1;
            vsync_n_reg     <= 1'b1;
            blank_n_reg     <= 1'b0;
            pixel_reg       <= 8'd0;
            frame_start_reg <= 1'b0;
        end else begin
            hsync_n_reg     <= ~flags_out.hs;
            vsync_n_reg     <= ~flags_out.vs;
            blank_n_reg     <= flags_out.active;
            pixel_reg       <= pixel_next;
            frame_start_reg <= flags_out.first;
        end
    end

    assign hsync_n     = hsync_n_reg;
    assign vsync_n     = vsync_n_reg;
    assign blank_n     = blank_n_reg;
    assign r           = pixel_reg;
    assign g           = pixel_reg;
    assign b           = pixel_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: three shrunken-geometry instances (RD_LAT 1..3, both
// luma bytes) run whole frames; one full 640x480 instance covers the first lines.
module tb_vga_frame_reader;

    localparam int NDUT = 4;

    function automatic int p_ha(int d);   return (d == 3) ? 640 : 64; endfunction
    function automatic int p_hfp(int d);  return (d == 3) ? 16  : 6;  endfunction
    function automatic int p_hs(int d);   return (d == 3) ? 96  : 10; endfunction
    function automatic int p_hbp(int d);  return (d == 3) ? 48  : 8;  endfunction
    function automatic int p_va(int d);   return (d == 3) ? 480 : 16; endfunction
    function automatic int p_vfp(int d);  return (d == 3) ? 10  : 2;  endfunction
    function automatic int p_vs(int d);   return (d == 3) ? 2   : 2;  endfunction
    function automatic int p_vbp(int d);  return (d == 3) ? 33  : 3;  endfunction
    function automatic int p_lat(int d);  return (d == 3) ? 1   : d + 1; endfunction
    function automatic int p_luma(int d); return (d == 0 || d == 2) ? 1 : 0; endfunction
    function automatic int p_ht(int d);   return p_ha(d) + p_hfp(d) + p_hs(d) + p_hbp(d); endfunction
    function automatic int p_vt(int d);   return p_va(d) + p_vfp(d) + p_vs(d) + p_vbp(d); endfunction

    logic        clk;
    logic        reset_n;
    logic [15:0] salt;
    int          edges;

    logic [15:0] rddata_w   [NDUT];
    logic [14:0] rdaddr_w   [NDUT];
    logic        hsync_w    [NDUT];
    logic        vsync_w    [NDUT];
    logic        blank_w    [NDUT];
    logic [7:0]  r_w        [NDUT];
    logic [7:0]  g_w        [NDUT];
    logic [7:0]  b_w        [NDUT];
    logic        fs_w       [NDUT];

    int test_cnt = 0;
    int fail_cnt = 0;
    int hlow    [NDUT];
    int vlow    [NDUT];
    int last_fs [NDUT];
    int fs_cnt  [NDUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    // Stored image: an address-dependent scrambled word, reseeded every run.
    function automatic logic [15:0] word_of(logic [14:0] a);
        logic [31:0] t;
        t = ({17'd0, a} * 32'h9E3779B1) ^ {16'd0, salt};
        return t[31:16] ^ t[15:0];
    endfunction

    function automatic logic [14:0] pix_addr(int h, int v);
        logic [7:0] x;
        logic [6:0] y;
        x = 8'(h / 4);
        y = 7'(v / 4);
        return {x, y};
    endfunction

    function automatic logic pos_visible(int d, int pos);
        int h;
        int v;
        if (pos < 0) return 1'b0;
        h = pos % p_ht(d);
        v = (pos / p_ht(d)) % p_vt(d);
        return (h < p_ha(d)) && (v < p_va(d));
    endfunction

    function automatic logic [7:0] pick(logic [15:0] w, int d);
        return (p_luma(d) != 0) ? w[15:8] : w[7:0];
    endfunction

    // Expected {hsync_n, vsync_n, blank_n, frame_start, r, g, b, rdaddr} n clocks after release.
    function automatic logic [42:0] expect_at(int d, int n);
        int p, h, v, q;
        int hs0, vs0;
        logic hs_n, vs_n, bl, fs;
        logic [7:0]  y;
        logic [14:0] a;
        hs_n = 1'b1; vs_n = 1'b1; bl = 1'b0; fs = 1'b0; y = 8'd0; a = 15'd0;
        hs0 = p_ha(d) + p_hfp(d);
        vs0 = p_va(d) + p_vfp(d);
        p = n - (p_lat(d) + 2);
        if (p >= 0) begin
            h = p % p_ht(d);
            v = (p / p_ht(d)) % p_vt(d);
            hs_n = !(h >= hs0 && h < hs0 + p_hs(d));
            vs_n = !(v >= vs0 && v < vs0 + p_vs(d));
            bl   = pos_visible(d, p);
            fs   = (h == 0) && (v == 0);
            if (bl) y = pick(word_of(pix_addr(h, v)), d);
        end
        q = n - 1;
        if (pos_visible(d, q)) a = pix_addr(q % p_ht(d), (q / p_ht(d)) % p_vt(d));
        return {hs_n, vs_n, bl, fs, y, y, y, a};
    endfunction

    function automatic logic [42:0] obs_of(int d);
        return {hsync_w[d], vsync_w[d], blank_w[d], fs_w[d], r_w[d], g_w[d], b_w[d], rdaddr_w[d]};
    endfunction

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : gen_dut
            localparam int LAT_G = p_lat(gi);
            logic [15:0] pipe [3];

            // Read port with LAT_G clocks of latency; X whenever the address is a blanking one.
            always @(posedge clk) begin
                if (pos_visible(gi, edges - 1)) pipe[0] <= word_of(rdaddr_w[gi]);
                else                            pipe[0] <= 16'hxxxx;
                pipe[1] <= pipe[0];
                pipe[2] <= pipe[1];
            end
            assign rddata_w[gi] = pipe[LAT_G - 1];

            vga_frame_reader #(
                .H_ACTIVE(p_ha(gi)), .H_FP(p_hfp(gi)), .H_SYNC(p_hs(gi)), .H_BP(p_hbp(gi)),
                .V_ACTIVE(p_va(gi)), .V_FP(p_vfp(gi)), .V_SYNC(p_vs(gi)), .V_BP(p_vbp(gi)),
                .SCALE_SHIFT(2), .RD_LAT(LAT_G), .LUMA_HI(p_luma(gi))
            ) u_dut (
                .clk(clk),
                .reset_n(reset_n),
                .rddata(rddata_w[gi]),
                .rdaddr(rdaddr_w[gi]),
                .hsync_n(hsync_w[gi]),
                .vsync_n(vsync_w[gi]),
                .blank_n(blank_w[gi]),
                .r(r_w[gi]),
                .g(g_w[gi]),
                .b(b_w[gi]),
                .frame_start(fs_w[gi])
            );
        end
    endgenerate

    task automatic check(string tag, int d, int n, logic [42:0] obs, logic [42:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s dut%0d n=%0d: got %h want %h", tag, d, n, obs, exp);
        end
    endtask

    task automatic clear_tracking();
        for (int d = 0; d < NDUT; d++) begin
            hlow[d] = 0; vlow[d] = 0; last_fs[d] = -1; fs_cnt[d] = 0;
        end
    endtask

    task automatic check_cycle(int n);
        for (int d = 0; d < NDUT; d++) begin
            check("pixel", d, n, obs_of(d), expect_at(d, n));
            if (!hsync_w[d]) hlow[d]++;
            else if (hlow[d] != 0) begin
                check("hsync_width", d, n, 43'(hlow[d]), 43'(p_hs(d)));
                hlow[d] = 0;
            end
            if (!vsync_w[d]) vlow[d]++;
            else if (vlow[d] != 0) begin
                check("vsync_width", d, n, 43'(vlow[d]), 43'(p_vs(d) * p_ht(d)));
                vlow[d] = 0;
            end
            if (fs_w[d]) begin
                if (last_fs[d] >= 0)
                    check("frame_period", d, n, 43'(n - last_fs[d]), 43'(p_ht(d) * p_vt(d)));
                else
                    check("first_frame_start", d, n, 43'(n), 43'(p_lat(d) + 2));
                last_fs[d] = n;
                fs_cnt[d]++;
            end
        end
    endtask

    task automatic check_reset(string tag, int n);
        for (int d = 0; d < NDUT; d++) check(tag, d, n, obs_of(d), expect_at(d, 0));
    endtask

    localparam int FRAME_S = 88 * 23;

    initial begin
        int n;
        salt    = 16'($urandom);
        reset_n = 1'b0;
        edges   = 0;
        clear_tracking();
        repeat (3) begin
            @(negedge clk);
            check_reset("reset_state", 0);
        end

        reset_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 3 * FRAME_S; k++) begin
            @(negedge clk);
            n = k;
            check_cycle(n);
            if (n == 3) begin
                check("full_fs_at_3", 3, n, 43'(fs_w[3]), 43'd1);
                check("full_blank_at_3", 3, n, 43'(blank_w[3]), 43'd1);
            end
            if (n == 1 + 636) check("addr_159_0", 3, n, 43'(rdaddr_w[3]), 43'({8'd159, 7'd0}));
            if (n == 1 + 640) check("addr_hblank", 3, n, 43'(rdaddr_w[3]), 43'd0);
            if (n == 1 + 4 * 800) check("addr_line4", 3, n, 43'(rdaddr_w[3]), 43'({8'd0, 7'd1}));
            for (int d = 0; d < 3; d++) begin
                if (n == p_lat(d) + 2 + 15 * 88 + 63)
                    check("last_pixel", d, n, 43'(r_w[d]), 43'(pick(word_of({8'd15, 7'd3}), d)));
            end
        end
        for (int d = 0; d < NDUT; d++)
            check("fs_count_3frames", d, n, 43'(fs_cnt[d]), 43'((d == 3) ? 1 : 3));

        // Stop mid-frame at hcnt=30, vcnt=10 of the small geometry.
        while (n < 3 * FRAME_S + 10 * 88 + 30) begin
            @(negedge clk);
            n++;
            check_cycle(n);
        end
        reset_n = 1'b0;
        #1;
        check_reset("async_reset", n);
        clear_tracking();
        repeat (2) begin
            @(negedge clk);
            check_reset("held_reset", n);
        end

        reset_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 2 * FRAME_S; k++) begin
            @(negedge clk);
            n = k;
            check_cycle(n);
        end
        for (int d = 0; d < NDUT; d++)
            check("fs_count_restart", d, n, 43'(fs_cnt[d]), 43'((d == 3) ? 1 : 2));

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
